// File: rtl/udp_tmp_pkg.sv
// Shared types and constants for the UDP temperature payload block.
// UDP_TMP_CHKSUM_EN selects the 9-byte frame with a trailing XOR checksum.
package udp_tmp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_BUSY  = 3'd2,
    ST_SEND  = 3'd3,
    ST_HOLD  = 3'd4
  } state_e;

  localparam logic [7:0] ASCII_T  = 8'h54;
  localparam logic [7:0] ASCII_M  = 8'h4D;
  localparam logic [7:0] ASCII_P  = 8'h50;
  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_Q  = 8'h3F;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

`ifdef UDP_TMP_CHKSUM_EN
  localparam int unsigned FRAME_LEN = 9;

  function automatic logic [7:0] frame_chksum(input logic [15:0] digits);
    return ASCII_T ^ ASCII_M ^ ASCII_P ^ ASCII_SP ^ digits[15:8] ^ digits[7:0] ^ ASCII_CR ^ ASCII_LF;
  endfunction
`else
  localparam int unsigned FRAME_LEN = 8;
`endif

  localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

  function automatic logic [7:0] frame_byte(input logic [3:0] idx, input logic [15:0] digits);
    logic [7:0] b;
    case (idx)
      4'd0:    b = ASCII_T;
      4'd1:    b = ASCII_M;
      4'd2:    b = ASCII_P;
      4'd3:    b = ASCII_SP;
      4'd4:    b = digits[15:8];
      4'd5:    b = digits[7:0];
      4'd6:    b = ASCII_CR;
      4'd7:    b = ASCII_LF;
`ifdef UDP_TMP_CHKSUM_EN
      4'd8:    b = frame_chksum(digits);
`endif
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/udp_tmp_payload_timer.sv
// udp_tmp_timer: loadable 32-bit down-counter that parks at zero and flags it.
module udp_tmp_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_val,
  output logic        zero
);

  logic [31:0] cnt_q, cnt_d;

  // next count: a load wins, otherwise step toward zero and stay there
  always_comb begin
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != 32'd0) begin
      cnt_d = cnt_q - 32'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == 32'd0);

endmodule

// File: rtl/udp_tmp_payload.sv
// udp_tmp_payload: periodic I2C temperature read serialized as an ASCII frame on a valid/ready stream.
// Define UDP_TMP_CHKSUM_EN for the 9-byte frame with an XOR checksum byte.
module udp_tmp_payload
  import udp_tmp_pkg::*;
#(
  parameter logic [31:0] P_PERIOD  = 32'd50_000_000,
  parameter logic [31:0] P_TIMEOUT = 32'd1_000_000
) (
  input  logic        i2c_clk,
  input  logic        rst,
  input  logic        i_enable,
  output logic        o_i2c_start,
  input  logic        i_i2c_end,
  input  logic [15:0] i_data_tmp_dec,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_tx_last,
  output logic        o_busy,
  output logic [7:0]  o_timeout_cnt
);

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] digits_q, digits_d;
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;
  logic [7:0]  data_q, data_d;
  logic        start_q, start_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;
  logic        busy_q, busy_d;
  logic        period_load_s, period_zero_s;
  logic        tmo_load_s, tmo_zero_s;

  // The period runs from entry into START; the read timeout from entry into BUSY.
  assign period_load_s = (state_d == ST_START);
  assign tmo_load_s    = (state_q == ST_START);

  udp_tmp_timer u_period (
    .clk      (i2c_clk),
    .rst      (rst),
    .load     (period_load_s),
    .load_val (P_PERIOD - 32'd1),
    .zero     (period_zero_s)
  );

  udp_tmp_timer u_timeout (
    .clk      (i2c_clk),
    .rst      (rst),
    .load     (tmo_load_s),
    .load_val (P_TIMEOUT - 32'd1),
    .zero     (tmo_zero_s)
  );

  // next state, latched digits, byte index and output values
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    digits_d  = digits_q;
    tmo_cnt_d = tmo_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (i_enable) begin
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        state_d = ST_BUSY;
      end
      ST_BUSY: begin
        // a completed read beats a timeout landing in the same cycle
        if (i_i2c_end) begin
          digits_d = i_data_tmp_dec;
          idx_d    = 4'd0;
          state_d  = ST_SEND;
        end else if (tmo_zero_s) begin
          digits_d = {ASCII_Q, ASCII_Q};
          if (tmo_cnt_q != 8'hFF) begin
            tmo_cnt_d = tmo_cnt_q + 8'd1;
          end else begin
            tmo_cnt_d = tmo_cnt_q;
          end
          idx_d   = 4'd0;
          state_d = ST_SEND;
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_SEND: begin
        if (i_tx_ready && (idx_q == LAST_IDX)) begin
          idx_d   = 4'd0;
          state_d = ST_HOLD;
        end else if (i_tx_ready) begin
          idx_d = idx_q + 4'd1;
        end else begin
          idx_d = idx_q;
        end
      end
      ST_HOLD: begin
        if (!i_enable) begin
          state_d = ST_IDLE;
        end else if (period_zero_s) begin
          state_d = ST_START;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d  = (state_d != ST_IDLE);
    start_d = (state_d == ST_START);
    valid_d = (state_d == ST_SEND);
    last_d  = (state_d == ST_SEND) && (idx_d == LAST_IDX);
    data_d  = (state_d == ST_SEND) ? frame_byte(idx_d, digits_d) : 8'h00;
  end

  // state and registered outputs
  always_ff @(posedge i2c_clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= 4'd0;
      digits_q  <= 16'h3030;
      tmo_cnt_q <= 8'd0;
      data_q    <= 8'd0;
      start_q   <= 1'b0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      digits_q  <= digits_d;
      tmo_cnt_q <= tmo_cnt_d;
      data_q    <= data_d;
      start_q   <= start_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
    end
  end

  assign o_i2c_start   = start_q;
  assign o_tx_valid    = valid_q;
  assign o_tx_data     = data_q;
  assign o_tx_last     = last_q;
  assign o_busy        = busy_q;
  assign o_timeout_cnt = tmo_cnt_q;

endmodule

// File: tb/tb_udp_tmp_payload.sv
// Self-checking bench for udp_tmp_payload: randomized reads and back-pressure against a frame/timing model.
module tb_udp_tmp_payload;

  localparam int PER = 100;
  localparam int TMO = 50;
`ifdef UDP_TMP_CHKSUM_EN
  localparam int FLEN = 9;
`else
  localparam int FLEN = 8;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        start;
  logic        i2c_end;
  logic [15:0] tmp;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_last;
  logic        busy;
  logic [7:0]  tmo_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int model_tmo = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  udp_tmp_payload #(.P_PERIOD(32'(PER)), .P_TIMEOUT(32'(TMO))) dut (
    .i2c_clk        (clk),
    .rst            (rst),
    .i_enable       (en),
    .o_i2c_start    (start),
    .i_i2c_end      (i2c_end),
    .i_data_tmp_dec (tmp),
    .o_tx_data      (tx_data),
    .o_tx_valid     (tx_valid),
    .i_tx_ready     (tx_ready),
    .o_tx_last      (tx_last),
    .o_busy         (busy),
    .o_timeout_cnt  (tmo_cnt)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // expected frame for a pair of digits
  task automatic make_frame(input logic [15:0] d);
    string hdr = "TMP ";
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(hdr[i]);
    exp_q.push_back(d[15:8]);
    exp_q.push_back(d[7:0]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`ifdef UDP_TMP_CHKSUM_EN
    begin
      logic [7:0] x;
      x = 8'h00;
      foreach (exp_q[i]) x = x ^ exp_q[i];
      exp_q.push_back(x);
    end
`endif
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, "_start"}, 32'(start), 32'd0);
    check_val({tag, "_valid"}, 32'(tx_valid), 32'd0);
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_last"}, 32'(tx_last), 32'd0);
    check_val({tag, "_data"}, 32'(tx_data), 32'd0);
    check_val({tag, "_tmo_cnt"}, 32'(tmo_cnt), 32'd0);
  endtask

  task automatic wait_start(input int budget, output int c);
    int n = 0;
    while (start !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check_val("start_seen", 32'(start), 32'd1);
    c = cyc;
  endtask

  // one read+frame, entered in the START cycle s; end pulse driven in cycle s+end_dly
  task automatic run_round(input int s, input int end_dly, input logic [15:0] d,
                           input int rmode, input bit drop_en, output int h);
    int first_v = -1;
    int idx = 0;
    int guard = 0;
    bit win;
    bit r;
    win = (end_dly <= TMO);
    tick();
    check_val("start_pulse_width", 32'(start), 32'd0);
    check_val("busy_in_read", 32'(busy), 32'd1);
    while (cyc < s + end_dly) begin
      tick();
      if (tx_valid === 1'b1 && first_v < 0) first_v = cyc;
    end
    i2c_end = 1'b1;
    tmp = d;
    tick();
    i2c_end = 1'b0;
    tmp = 16'($urandom);
    if (tx_valid === 1'b1 && first_v < 0) first_v = cyc;
    if (win) begin
      make_frame(d);
    end else begin
      make_frame(16'h3F3F);
      if (model_tmo < 255) model_tmo++;
    end
    check_val("send_entry_cycle", first_v, win ? s + end_dly + 1 : s + TMO + 1);
    while (idx < FLEN && guard < 4000) begin
      check_val("tx_valid", 32'(tx_valid), 32'd1);
      check_val("tx_data", 32'(tx_data), 32'(exp_q[idx]));
      check_val("tx_last", 32'(tx_last), 32'(idx == FLEN - 1));
      if (tx_valid !== 1'b1) break;
      case (rmode)
        0:       r = 1'b1;
        1:       r = guard[0];
        2:       r = 1'($urandom);
        default: r = (guard >= 200);
      endcase
      tx_ready = r;
      if (drop_en && idx == 3) en = 1'b0;
      tick();
      if (r) idx++;
      guard++;
    end
    tx_ready = 1'b0;
    check_val("frame_bytes", idx, FLEN);
    h = cyc;
    check_val("valid_after_frame", 32'(tx_valid), 32'd0);
    check_val("busy_in_hold", 32'(busy), 32'd1);
    check_val("timeout_cnt", 32'(tmo_cnt), model_tmo);
  endtask

  // next start is one period after the last, unless the frame overran it
  task automatic next_start(input int s, input int h, output int s_n);
    int exp_c;
    exp_c = (s + PER > h + 1) ? s + PER : h + 1;
    wait_start(PER + 400, s_n);
    check_val("start_cycle", s_n, exp_c);
  endtask

  initial begin
    int s;
    int h;
    int c0;
    int n_st;
    rst = 1'b1;
    en = 1'b0;
    i2c_end = 1'b0;
    tmp = 16'h0000;
    tx_ready = 1'b0;
    tick();
    tick();
    check_quiet("reset");
    rst = 1'b0;
    tick();
    check_val("idle_disabled_busy", 32'(busy), 32'd0);

    // nominal read, ready always high
    en = 1'b1;
    c0 = cyc;
    wait_start(10, s);
    check_val("first_start_cycle", s, c0 + 1);
    run_round(s, 19, 16'h3235, 0, 1'b0, h);
    next_start(s, h, s);

    // alternating ready
    run_round(s, 19, 16'h3235, 1, 1'b0, h);
    next_start(s, h, s);

    // randomized digits, read latency and ready
    for (int i = 0; i < 8; i++) begin
      run_round(s, $urandom_range(1, 60), 16'($urandom), 2, 1'b0, h);
      next_start(s, h, s);
    end

    // end pulse coincident with timeout expiry, then just after it
    run_round(s, TMO, 16'h3139, 2, 1'b0, h);
    next_start(s, h, s);
    run_round(s, TMO + 1, 16'h3139, 0, 1'b0, h);
    next_start(s, h, s);

    // timeout counter saturation
    for (int i = 0; i < 256; i++) begin
      run_round(s, TMO + 5, 16'($urandom), 0, 1'b0, h);
      next_start(s, h, s);
    end
    check_val("tmo_saturated", 32'(tmo_cnt), 32'd255);

    // long back-pressure overruns the period
    run_round(s, 10, 16'($urandom), 3, 1'b0, h);
    next_start(s, h, s);

    // enable dropped mid-frame: frame completes, then idle
    run_round(s, 12, 16'h3734, 2, 1'b1, h);
    tick();
    check_val("idle_after_drop", 32'(busy), 32'd0);
    n_st = 0;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (start === 1'b1) n_st++;
    end
    check_val("no_start_when_disabled", n_st, 0);

    // reset in the middle of a frame
    en = 1'b1;
    wait_start(10, s);
    tick();
    while (cyc < s + 5) tick();
    i2c_end = 1'b1;
    tmp = 16'h4142;
    tick();
    i2c_end = 1'b0;
    make_frame(16'h4142);
    tx_ready = 1'b1;
    tick();
    tick();
    tick();
    tx_ready = 1'b0;
    check_val("pre_reset_byte3", 32'(tx_data), 32'(exp_q[3]));
    rst = 1'b1;
    en = 1'b0;
    tick();
    rst = 1'b0;
    model_tmo = 0;
    check_quiet("mid_frame_reset");
    tick();
    tick();
    check_val("idle_after_reset", 32'(busy), 32'd0);
    en = 1'b1;
    c0 = cyc;
    wait_start(10, s);
    check_val("restart_cycle", s, c0 + 1);
    run_round(s, 8, 16'($urandom), 2, 1'b0, h);
    next_start(s, h, s);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
